// File: rtl/sumador_restador_serie.sv
// +----------------------------------------------------------------------------+
// | Module  : sumador_restador_serie                                           |
// | Brief   : Multi-cycle CHUNK-sliced two's-complement adder/subtractor with  |
// |           valid/ready handshakes and cout/ovf/zero flags.                  |
// |           Optional macro SUMRES_SAT_EN: clamp result on signed overflow.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module sumador_restador_serie #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             in_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int c_NCHUNK = WIDTH / CHUNK;
  localparam int c_KW     = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
  localparam logic [c_KW-1:0] c_LAST = c_KW'(c_NCHUNK - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [c_KW-1:0]  r_k;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_final;
  logic             w_ovf;

  always_comb begin
    w_sum = {1'b0, r_a[int'(r_k)*CHUNK +: CHUNK]}
          + {1'b0, r_b[int'(r_k)*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, r_carry};
    w_res = r_s;
    w_res[int'(r_k)*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
    // Carry into the MSB recovered from the MSB sum bit; only meaningful on the last slice.
    w_ovf = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_res[WIDTH-1] ^ w_sum[CHUNK];
    w_final = w_res;
`ifdef SUMRES_SAT_EN
    if (w_ovf) begin
      w_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= c_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b ^ {WIDTH{in_sub}};
            r_carry <= in_sub;
            r_k     <= '0;
            r_state <= c_BUSY;
          end
        end
        c_BUSY: begin
          r_carry <= w_sum[CHUNK];
          r_k     <= r_k + 1'b1;
          if (r_k == c_LAST) begin
            r_s     <= w_final;
            r_cout  <= w_sum[CHUNK];
            r_ovf   <= w_ovf;
            r_zero  <= (w_final == '0);
            r_state <= c_DONE;
          end else begin
            r_s <= w_res;
          end
        end
        c_DONE: begin
          if (in_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign out_ready = (r_state == c_IDLE);
  assign out_valid = (r_state == c_DONE);
  assign out_s     = r_s;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
  assign out_zero  = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_sumador_restador_serie.sv
// Testbench for sumador_restador_serie (WIDTH=16, CHUNK=4): vector table,
// random sweep against an arithmetic model, backpressure and async reset cases.
`default_nettype none

module tb_sumador_restador_serie;

  localparam int W = 16;
  localparam int C = 4;
  localparam int NCH = W / C;
`ifdef SUMRES_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         in_ready;
  logic [W-1:0] out_s;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  int n_checks = 0;
  int n_errors = 0;

  sumador_restador_serie #(.WIDTH(W), .CHUNK(C)) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .in_ready (in_ready),
    .out_s    (out_s),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic.
  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    vec_t v;
    int sa, sb, r, ua, ub;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    r = sub ? sa - sb : sa + sb;
    v.a = a; v.b = b; v.sub = sub;
    v.s = r[W-1:0];
    v.cout = sub ? (ua >= ub) : ((ua + ub) > 65535);
    v.ovf = (r > 32767) || (r < -32768);
    if (SAT && v.ovf) v.s = (r > 0) ? 16'h7FFF : 16'h8000;
    v.zero = (v.s == 0);
    return v;
  endfunction

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input string tag);
    @(negedge clk);
    chk({tag, " ready_before"}, {31'd0, out_ready}, 32'd1);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, lat, NCH);
  endtask

  task automatic check_res(input vec_t e, input string tag);
    chk({tag, " s"}, {16'd0, out_s}, {16'd0, e.s});
    chk({tag, " cout"}, {31'd0, out_cout}, {31'd0, e.cout});
    chk({tag, " ovf"}, {31'd0, out_ovf}, {31'd0, e.ovf});
    chk({tag, " zero"}, {31'd0, out_zero}, {31'd0, e.zero});
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    chk({tag, " valid_after_hs"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " ready_after_hs"}, {31'd0, out_ready}, 32'd1);
  endtask

  task automatic run_op(input vec_t e, input string tag);
    accept(e.a, e.b, e.sub, tag);
    wait_done(tag);
    check_res(e, tag);
    handshake(tag);
  endtask

  vec_t tbl[7];

  initial begin
    vec_t e;
    logic [W-1:0] held_s;
    logic [2:0] held_f;

    tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, !SAT};

    rst_n = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0;
    #12;
    chk("reset ready", {31'd0, out_ready}, 32'd1);
    chk("reset valid", {31'd0, out_valid}, 32'd0);
    chk("reset s", {16'd0, out_s}, 32'd0);
    chk("reset flags", {29'd0, out_cout, out_ovf, out_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      e = model(W'($urandom), W'($urandom), 1'($urandom));
      run_op(e, $sformatf("rnd%0d", i));
    end

    // Backpressure: result frozen while in_ready stays low.
    e = model(16'h4321, 16'h1111, 1'b1);
    accept(e.a, e.b, e.sub, "bp");
    wait_done("bp");
    held_s = out_s;
    held_f = {out_cout, out_ovf, out_zero};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_a = W'($urandom);
      in_sub = ~in_sub;
      @(posedge clk);
      #1;
      chk("bp valid", {31'd0, out_valid}, 32'd1);
      chk("bp ready", {31'd0, out_ready}, 32'd0);
      chk("bp s", {16'd0, out_s}, {16'd0, held_s});
      chk("bp flags", {29'd0, out_cout, out_ovf, out_zero}, {29'd0, held_f});
    end
    in_valid = 1'b0;
    check_res(e, "bp");
    handshake("bp");

    // Async reset in the second BUSY cycle.
    accept(16'h1357, 16'h2468, 1'b0, "rst");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst valid", {31'd0, out_valid}, 32'd0);
    chk("rst ready", {31'd0, out_ready}, 32'd1);
    chk("rst s", {16'd0, out_s}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst held valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(model(16'h0001, 16'h0001, 1'b0), "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/sumador_restador_serie.md
# sumador_restador_serie

Parametrised, multi-cycle two's-complement adder/subtractor. Each operation is processed in CHUNK-bit slices, one slice per clock, with a registered carry between slices. A valid/ready handshake sits on each side. It replaces the fixed 4-bit combinational adder/subtractor in datapaths where width grows and area matters more than latency. Flags report carry/borrow, signed overflow and zero.

## Interface

- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK ≥ 1.

- in_clk  input  1  clock; all state updates on the rising edge.
- in_rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  operand request.
- out_ready  output  1  block can accept a request.
- in_a  input  WIDTH  minuend / first addend.
- in_b  input  WIDTH  subtrahend / second addend.
- in_sub  input  1  0 = add, 1 = subtract (a − b).
- out_valid  output  1  result available.
- in_ready  input  1  downstream accepts the result.
- out_s  output  WIDTH  result.
- out_cout  output  1  carry out. On subtract, 1 = no borrow (a ≥ b unsigned).
- out_ovf  output  1  signed overflow.
- out_zero  output  1  out_s == 0.

## Operation

- FSM states IDLE, BUSY, DONE. Reset enters IDLE.
- IDLE: out_ready = 1. When in_valid is high at an edge, the block:
  - captures in_a;
  - captures in_b XOR {WIDTH{in_sub}};
  - loads the carry register with in_sub;
  - clears the slice counter;
  - moves to BUSY.
- BUSY: out_ready = 0. Each edge computes slice k (bits k·CHUNK+CHUNK−1 : k·CHUNK) as a_k + b'_k + carry. It writes that slice of the result register, updates the carry and increments k. After slice NCHUNK−1 it moves to DONE.
- Last slice also captures the carry into the MSB. This gives out_ovf = carry_into_msb XOR carry_out and out_cout = carry_out.
- DONE: out_valid = 1. out_s and all flags are held stable until in_valid... no: until in_ready is high at an edge. Then the block returns to IDLE.
- Inputs are sampled only at acceptance. Changes to in_a, in_b or in_sub while BUSY or DONE are ignored.
- in_valid outside IDLE is ignored and no request is queued.
- out_zero is computed on the final (post-saturation) out_s.
- Arithmetic is modulo 2^WIDTH. No sign extension is performed.

## Timing

- Reset values:
  - State = IDLE, out_ready = 1, out_valid = 0.
  - out_s = 0, out_cout = 0, out_ovf = 0, out_zero = 0.
- Latency: with acceptance at edge E0, slices complete at E1…E_NCHUNK. out_valid rises after E_NCHUNK, NCHUNK cycles after acceptance.
- NCHUNK = 1 gives single-cycle BUSY.
- Minimum initiation interval is NCHUNK + 2 cycles (accept, NCHUNK slices, DONE handshake).
- The DONE→IDLE edge does not accept new operands. out_ready rises the cycle after the result handshake.
- Reset asserted mid-operation (BUSY or DONE) takes effect immediately, without waiting for an edge:
  - all outputs go to their reset values;
  - the in-flight operation is discarded and no partial result is ever presented.
- If in_ready is held low, DONE persists indefinitely with outputs frozen.

## Configuration

- SUMRES_SAT_EN defined: on signed overflow, out_s clamps to the signed limit.
  - Positive overflow gives 0x7FF…F.
  - Negative overflow gives 0x800…0.
  - out_ovf = 1 and out_cout is reported unmodified.
- SUMRES_SAT_EN undefined: out_s wraps modulo 2^WIDTH; out_ovf is still reported.
- Latency is identical in both builds. Clamping is applied on the transition into DONE.

## Test plan

- WIDTH=16, CHUNK=4; 0x1234 + 0x0FFF, in_sub=0 -> out_valid exactly 4 cycles after acceptance; out_s=0x2233, cout=0, ovf=0, zero=0.
- 0x0005 − 0x0007 -> out_s=0xFFFE, cout=0 (borrow), ovf=0; 0xFFFF + 0x0001 -> out_s=0x0000, cout=1, zero=1, ovf=0.
- 0x7FFF + 0x0001 -> ovf=1; out_s=0x8000 without SUMRES_SAT_EN, 0x7FFF with it. 0x8000 − 0x0001 -> ovf=1; out_s=0x7FFF without it, 0x8000 with it.
- Backpressure: hold in_ready=0 for 5 cycles in DONE while toggling in_valid/in_a -> out_valid, out_s and flags unchanged and out_ready=0. out_ready=1 one cycle after in_ready handshake.
- Assert in_rst_n=0 during the second BUSY cycle -> out_valid=0, out_ready=1, out_s=0 immediately. The next request 0x0001 + 0x0001 yields 0x0002.
- CHUNK=16 (NCHUNK=1) and CHUNK=1 (NCHUNK=16) builds: random operand sweep matches the reference model a±b. Latencies are 1 and 16 respectively.
